// File: rtl/register_file.sv
// Sixteen-entry, two-write / two-read register file with combinational reads,
// an optional low-byte mode on ports 1/2, and an always-visible R15 tap.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  first_byte_only,
  input  logic                  write_enable_1,
  input  logic [ADDR_WIDTH-1:0] write_addr_1,
  input  logic [DATA_WIDTH-1:0] write_data_1,
  input  logic                  write_enable_2,
  input  logic [ADDR_WIDTH-1:0] write_addr_2,
  input  logic [DATA_WIDTH-1:0] write_data_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic [DATA_WIDTH-1:0] read_data_15
);

  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int BYTE_WIDTH = 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Byte mode keeps only the low byte and zeroes everything above it.
  function automatic logic [DATA_WIDTH-1:0] low_byte_mask(
    input logic [DATA_WIDTH-1:0] value,
    input logic                  byte_mode
  );
    logic [DATA_WIDTH-1:0] masked;
    masked = '0;
    masked[BYTE_WIDTH-1:0] = value[BYTE_WIDTH-1:0];
    return byte_mode ? masked : value;
  endfunction

  logic [DATA_WIDTH-1:0] wr_value_1;
  logic [DATA_WIDTH-1:0] wr_value_2;

  assign wr_value_1 = low_byte_mask(write_data_1, first_byte_only);
  assign wr_value_2 = low_byte_mask(write_data_2, first_byte_only);

  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path leaves it unassigned, which would infer a latch.
    regs_d = regs_q;
    if (write_enable_2) begin
      regs_d[write_addr_2] = wr_value_2;
    end
    // Port 1 is applied last so it overrides port 2 on an address collision.
    if (write_enable_1) begin
      regs_d[write_addr_1] = wr_value_1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: this array is built from flops and must read zero during reset, so every entry is cleared; a RAM macro would not be reset.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign read_data_1  = low_byte_mask(regs_q[read_addr_1], first_byte_only);
  assign read_data_2  = low_byte_mask(regs_q[read_addr_2], first_byte_only);
  assign read_data_15 = regs_q[NUM_REGS-1];

endmodule

// File: tb/tb_register_file.sv
// Directed test of register_file: stimulus pushes expected read values into a
// scoreboard queue and a separate monitor samples the DUT and compares.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        first_byte_only;
  logic        write_enable_1;
  logic [3:0]  write_addr_1;
  logic [15:0] write_data_1;
  logic        write_enable_2;
  logic [3:0]  write_addr_2;
  logic [15:0] write_data_2;
  logic [3:0]  read_addr_1;
  logic [3:0]  read_addr_2;
  logic [15:0] read_data_1;
  logic [15:0] read_data_2;
  logic [15:0] read_data_15;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .first_byte_only (first_byte_only),
    .write_enable_1  (write_enable_1),
    .write_addr_1    (write_addr_1),
    .write_data_1    (write_data_1),
    .write_enable_2  (write_enable_2),
    .write_addr_2    (write_addr_2),
    .write_data_2    (write_data_2),
    .read_addr_1     (read_addr_1),
    .read_addr_2     (read_addr_2),
    .read_data_1     (read_data_1),
    .read_data_2     (read_data_2),
    .read_data_15    (read_data_15)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {P_RD1, P_RD2, P_RD15} port_e;

  typedef struct {
    string       name;
    port_e       port;
    logic [15:0] exp;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: whenever the stimulus announces a sample point, drain the queue.
  initial begin
    forever begin
      @(sample_ev);
      while (exp_q.size() != 0) begin
        exp_t e;
        logic [15:0] act;
        e = exp_q.pop_front();
        case (e.port)
          P_RD1:   act = read_data_1;
          P_RD2:   act = read_data_2;
          default: act = read_data_15;
        endcase
        check(e.name, act, e.exp);
      end
    end
  end

  task automatic expect_rd(input string name, input port_e port, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    exp_q.push_back(e);
    #1;
    ->sample_ev;
    #1;
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst             = 1'b1;
    first_byte_only = 1'b0;
    write_enable_1  = 1'b0;
    write_addr_1    = '0;
    write_data_1    = '0;
    write_enable_2  = 1'b0;
    write_addr_2    = '0;
    write_data_2    = '0;
    read_addr_1     = '0;
    read_addr_2     = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state sweep.
    for (int i = 0; i < 16; i++) begin
      read_addr_1 = 4'(i);
      expect_rd($sformatf("reset_rd1_r%0d", i), P_RD1, 16'h0000);
    end
    expect_rd("reset_rd15", P_RD15, 16'h0000);
    expect_rd("reset_rd2", P_RD2, 16'h0000);

    // Write R13 = FFFF, visible only after the edge.
    write_enable_1 = 1'b1; write_addr_1 = 4'hD; write_data_1 = 16'hFFFF;
    read_addr_2 = 4'hD;
    expect_rd("r13_before_edge", P_RD2, 16'h0000);
    tick();
    expect_rd("r13_after_edge", P_RD2, 16'hFFFF);

    // New data appears only after the following edge.
    write_data_1 = 16'hAAAA;
    expect_rd("r13_no_bypass", P_RD2, 16'hFFFF);
    tick();
    expect_rd("r13_aaaa", P_RD2, 16'hAAAA);

    // Port 2 writes R15; then a collision where port 1 wins.
    write_enable_1 = 1'b0;
    write_enable_2 = 1'b1; write_addr_2 = 4'hF; write_data_2 = 16'hAFAF;
    tick();
    expect_rd("r15_port2", P_RD15, 16'hAFAF);
    write_enable_1 = 1'b1; write_addr_1 = 4'hF; write_data_1 = 16'h1234;
    tick();
    expect_rd("r15_collision_p1_wins", P_RD15, 16'h1234);
    expect_rd("r13_untouched", P_RD2, 16'hAAAA);

    // Two writes to different addresses on one edge.
    write_addr_1 = 4'h1; write_data_1 = 16'h1111;
    write_addr_2 = 4'h2; write_data_2 = 16'h2222;
    tick();
    read_addr_1 = 4'h1; read_addr_2 = 4'h2;
    expect_rd("dual_write_r1", P_RD1, 16'h1111);
    expect_rd("dual_write_r2", P_RD2, 16'h2222);

    // R0 is an ordinary register.
    write_enable_2 = 1'b0;
    write_addr_1 = 4'h0; write_data_1 = 16'hBEEF;
    tick();
    read_addr_1 = 4'h0;
    expect_rd("r0_writable", P_RD1, 16'hBEEF);

    // Disabled ports change nothing.
    write_enable_1 = 1'b0; write_data_1 = 16'h0BAD;
    write_addr_2 = 4'h0; write_data_2 = 16'hDEAD;
    tick();
    expect_rd("r0_hold_we_low", P_RD1, 16'hBEEF);

    // Byte-mode write clears the upper byte; both ports read the same address.
    first_byte_only = 1'b1;
    write_enable_1 = 1'b1; write_addr_1 = 4'h9; write_data_1 = 16'hAFAF;
    read_addr_1 = 4'h9; read_addr_2 = 4'h9;
    tick();
    write_enable_1 = 1'b0;
    expect_rd("byte_write_rd1", P_RD1, 16'h00AF);
    expect_rd("byte_write_rd2", P_RD2, 16'h00AF);
    first_byte_only = 1'b0;
    expect_rd("byte_write_stored", P_RD1, 16'h00AF);

    // Full-width preload, then byte-mode read masking; R15 tap stays unmasked.
    write_enable_1 = 1'b1; write_data_1 = 16'hFFFF;
    tick();
    write_enable_1 = 1'b0;
    expect_rd("r9_full_preload", P_RD1, 16'hFFFF);
    first_byte_only = 1'b1;
    expect_rd("byte_read_rd1", P_RD1, 16'h00FF);
    expect_rd("byte_read_rd2", P_RD2, 16'h00FF);
    expect_rd("rd15_unmasked", P_RD15, 16'h1234);

    // Byte-mode write through port 2 to R15.
    write_enable_2 = 1'b1; write_addr_2 = 4'hF; write_data_2 = 16'h5678;
    tick();
    write_enable_2 = 1'b0;
    expect_rd("r15_byte_write", P_RD15, 16'h0078);
    first_byte_only = 1'b0;

    // Asynchronous reset mid-cycle.
    write_enable_1 = 1'b1; write_addr_1 = 4'h3; write_data_1 = 16'h5A5A;
    tick();
    write_enable_1 = 1'b0;
    read_addr_1 = 4'h3;
    expect_rd("r3_written", P_RD1, 16'h5A5A);
    rst = 1'b1;
    expect_rd("r3_async_reset", P_RD1, 16'h0000);
    expect_rd("r15_async_reset", P_RD15, 16'h0000);

    // A write whose edge falls during reset is lost.
    write_enable_1 = 1'b1; write_addr_1 = 4'h4; write_data_1 = 16'h4444;
    read_addr_2 = 4'h4;
    tick();
    write_enable_1 = 1'b0;
    rst = 1'b0;
    expect_rd("write_lost_in_reset", P_RD2, 16'h0000);
    tick();
    expect_rd("write_lost_after_release", P_RD2, 16'h0000);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DATA_WIDTH SHALL default to 16 and set the register and data-port width; all widths below assume the default.
REQ-003 Parameter ADDR_WIDTH SHALL default to 4 and set the address width; the file holds 2**ADDR_WIDTH = 16 registers, R0..R15.
REQ-004 clk  input  1  SHALL be the clock; all register updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous active-high reset that clears every register.
REQ-006 first_byte_only  input  1  SHALL be the byte-mode select; 1 selects low-byte write and low-byte read on ports 1/2.
REQ-007 write_enable_1  input  1  SHALL be the write strobe for port 1.
REQ-008 write_addr_1  input  4  SHALL be the destination register for port 1.
REQ-009 write_data_1  input  16  SHALL be the write data for port 1.
REQ-010 write_enable_2  input  1  SHALL be the write strobe for port 2.
REQ-011 write_addr_2  input  4  SHALL be the destination register for port 2.
REQ-012 write_data_2  input  16  SHALL be the write data for port 2.
REQ-013 read_addr_1  input  4  SHALL be the source register for read port 1.
REQ-014 read_addr_2  input  4  SHALL be the source register for read port 2.
REQ-015 read_data_1  output  16  SHALL be the contents of R[read_addr_1], subject to byte mode.
REQ-016 read_data_2  output  16  SHALL be the contents of R[read_addr_2], subject to byte mode.
REQ-017 read_data_15  output  16  SHALL be the full 16-bit contents of R15 at all times.

Function
REQ-018 Writes SHALL be synchronous: on a rising clk edge with write_enable_n=1 and rst=0, R[write_addr_n] SHALL load the port's write value.
REQ-019 With write_enable_n=0, port n SHALL leave every register unchanged.
REQ-020 Reads SHALL be combinational, with zero-cycle latency from any change in address or register contents.
REQ-021 A written value SHALL first appear on the read outputs immediately after the capturing edge; there is no write-to-read bypass before that edge.
REQ-022 When first_byte_only=0, the port write value SHALL be write_data_n[15:0].
REQ-023 When first_byte_only=1, the port write value SHALL be {8'h00, write_data_n[7:0]}, so the upper byte is cleared.
REQ-024 When first_byte_only=1, read_data_1 and read_data_2 SHALL output {8'h00, R[addr][7:0]}.
REQ-025 When first_byte_only=0, read_data_1 and read_data_2 SHALL output R[addr][15:0].
REQ-026 read_data_15 SHALL never be masked by first_byte_only.
REQ-027 If both ports write the same address on the same edge, port 1 SHALL win and the port 2 write to that address SHALL be discarded.
REQ-028 If the two ports write different addresses on the same edge, both writes SHALL complete on that edge.
REQ-029 R0 SHALL be an ordinary writable register, not hardwired to zero.
REQ-030 Both read ports SHALL be able to read the same address simultaneously.

Reset
REQ-031 While rst=1, all 16 registers SHALL be 16'h0000 immediately, independent of clk, and all writes SHALL be ignored.
REQ-032 After reset, read_data_1, read_data_2 and read_data_15 SHALL be 16'h0000.
REQ-033 Asserting rst between edges SHALL clear all registers at once; a write whose capturing edge falls while rst=1 SHALL be lost.

Verification
REQ-034 Pulse rst, then sweep read_addr_1 over 0..15 -> read_data_1 = 0000 at every address and read_data_15 = 0000.
REQ-035 we1=1, wa1=D, wd1=FFFF, ra2=D -> read_data_2 = FFFF after the next rising edge and 0000 before it.
REQ-036 Keep we1=1, wa1=D and change wd1 to AAAA -> read_data_2 = AAAA only after the following rising edge.
REQ-037 we2=1, wa2=F, wd2=AFAF -> read_data_15 = AFAF after the edge; also drive we1=1, wa1=F, wd1=1234 on the same edge -> R15 = 1234.
REQ-038 first_byte_only=1, we1=1, wa1=9, wd1=AFAF, ra1=ra2=9 -> read_data_1 = read_data_2 = 00AF; pre-load R9=FFFF with byte mode 0, then set byte mode 1 without writing -> both reads = 00FF.
REQ-039 Write R3=5A5A, then assert rst mid-cycle -> read_data for R3 = 0000 immediately, before any clk edge.
